// File: rtl/ofifo_align_if.sv
// Bus bundle for the ofifo_align column aligner: per-column write lanes in, aligned rows out.
// o_err exists only when OFIFO_ERR_EN is defined.
interface ofifo_align_if #(
  parameter int COLS   = 8,
  parameter int DATA_W = 16
);
  logic [COLS*DATA_W-1:0] in;
  logic [COLS-1:0]        wr;
  logic                   rd;
  logic [COLS*DATA_W-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
`ifdef OFIFO_ERR_EN
  logic                   o_err;

  modport master (output in, wr, rd, input out, o_valid, o_full, o_ready, o_err);
  modport slave  (input in, wr, rd, output out, o_valid, o_full, o_ready, o_err);
`else
  modport master (output in, wr, rd, input out, o_valid, o_full, o_ready);
  modport slave  (input in, wr, rd, output out, o_valid, o_full, o_ready);
`endif
endinterface

// File: rtl/ofifo_align.sv
// Drain-side column aligner: one circular buffer per array column, popped together as whole rows.
// Optional sticky error flag (dropped write / ignored read) enabled by OFIFO_ERR_EN.
module ofifo_align #(
  parameter int COLS   = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input logic         clk,
  input logic         reset,
  ofifo_align_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef logic signed [DATA_W-1:0] word_t;

  word_t                  mem [COLS][DEPTH];
  logic [AW-1:0]          wptr [COLS];
  logic [AW-1:0]          rptr [COLS];
  logic [AW:0]            cnt  [COLS];
  logic [COLS-1:0]        empty;
  logic [COLS-1:0]        full;
  logic [COLS-1:0]        wr_acc;
  logic                   rd_acc;
  logic [COLS*DATA_W-1:0] out_p1;

  // Flags come from start-of-cycle counts, so a same-cycle read never frees room for a write.
  always_comb begin
    empty  = '0;
    full   = '0;
    wr_acc = '0;
    for (int i = 0; i < COLS; i++) begin
      empty[i]  = (cnt[i] == '0);
      full[i]   = (cnt[i] == (AW+1)'(DEPTH));
      wr_acc[i] = bus.wr[i] & ~full[i];
    end
  end

  assign bus.o_valid = &(~empty);
  assign bus.o_full  = |full;
  assign bus.o_ready = ~bus.o_full;
  assign rd_acc      = bus.rd & bus.o_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COLS; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < COLS; i++) begin
        if (wr_acc[i]) wptr[i] <= wptr[i] + AW'(1);
        if (rd_acc)    rptr[i] <= rptr[i] + AW'(1);
        case ({wr_acc[i], rd_acc})
          2'b10:   cnt[i] <= cnt[i] + (AW+1)'(1);
          2'b01:   cnt[i] <= cnt[i] - (AW+1)'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < COLS; i++) begin
      if (wr_acc[i]) mem[i][wptr[i]] <= word_t'(bus.in[i*DATA_W +: DATA_W]);
    end
  end

  // ---- stage p1: registered aligned row ----
  always_ff @(posedge clk) begin
    if (reset) begin
      out_p1 <= '0;
    end else if (rd_acc) begin
      for (int i = 0; i < COLS; i++) begin
        out_p1[i*DATA_W +: DATA_W] <= mem[i][rptr[i]];
      end
    end
  end

  assign bus.out = out_p1;

`ifdef OFIFO_ERR_EN
  logic err;

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((|(bus.wr & full)) || (bus.rd && !bus.o_valid)) begin
      err <= 1'b1;
    end
  end

  assign bus.o_err = err;
`endif
endmodule

// File: tb/tb_ofifo_align.sv
// Bench for ofifo_align: directed table for the skewed fill plus hand-written corner sequences,
// with a per-column queue model checked every cycle.
module tb_ofifo_align;
  localparam int COLS = 8, BW = 16, DEPTH = 64, W = COLS*BW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ofifo_align_if #(.COLS(COLS), .DATA_W(BW)) bus();
  ofifo_align #(.COLS(COLS), .DATA_W(BW), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  logic [BW-1:0] mq [COLS][$];
  logic [W-1:0]  mout;
  logic          merr;
  int            drops;
  int            rows_read;

  typedef struct packed {
    logic [COLS-1:0] wr;
    logic            rd;
    logic [W-1:0]    din;
    logic            exp_valid;
    logic            chk_out;
    logic [W-1:0]    exp_out;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mkrow(input logic [BW-1:0] base);
    logic [W-1:0] r;
    for (int i = 0; i < COLS; i++) r[i*BW +: BW] = base + BW'(i);
    return r;
  endfunction

  function automatic logic mvalid();
    for (int i = 0; i < COLS; i++) if (mq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic mfull();
    for (int i = 0; i < COLS; i++) if (mq[i].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic [COLS-1:0] w, input logic r, input logic [W-1:0] d, input logic rs);
    int   sz [COLS];
    logic v;
    if (rs) begin
      for (int i = 0; i < COLS; i++) mq[i].delete();
      mout = '0;
      merr = 1'b0;
      return;
    end
    v = 1'b1;
    for (int i = 0; i < COLS; i++) begin
      sz[i] = mq[i].size();
      if (sz[i] == 0) v = 1'b0;
    end
    if (r && v) begin
      for (int i = 0; i < COLS; i++) mout[i*BW +: BW] = mq[i].pop_front();
      rows_read++;
    end else if (r) begin
      merr = 1'b1;
    end
    for (int i = 0; i < COLS; i++) begin
      if (w[i]) begin
        if (sz[i] < DEPTH) mq[i].push_back(d[i*BW +: BW]);
        else begin
          merr = 1'b1;
          drops++;
        end
      end
    end
  endtask

  task automatic step(input logic [COLS-1:0] w, input logic r, input logic [W-1:0] d, input logic rs);
    bus.wr = w;
    bus.rd = r;
    bus.in = d;
    reset  = rs;
    model_step(w, r, d, rs);
    @(posedge clk);
    #1;
    check("out", bus.out, mout);
    check("o_valid", W'(bus.o_valid), W'(mvalid()));
    check("o_full", W'(bus.o_full), W'(mfull()));
    check("o_ready", W'(bus.o_ready), W'(!mfull()));
`ifdef OFIFO_ERR_EN
    check("o_err", W'(bus.o_err), W'(merr));
`endif
  endtask

  initial begin
    logic [W-1:0] d;
    int           wcnt [COLS];
    logic [COLS-1:0] w;
    int           guard;

    bus.wr = '0;
    bus.rd = 1'b0;
    bus.in = '0;
    mout = '0;
    merr = 1'b0;
    drops = 0;
    rows_read = 0;

    // Skewed fill: column i writes cycles i..i+3; reads on cycles 11..14.
    for (int k = 0; k < 15; k++) begin
      tbl[k].wr = '0;
      for (int i = 0; i < COLS; i++) tbl[k].wr[i] = (k >= i) && (k <= i + 3);
      tbl[k].rd        = (k >= 11);
      tbl[k].din       = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
      tbl[k].exp_valid = (k >= 7) && (k <= 13);
      tbl[k].chk_out   = (k >= 11);
      tbl[k].exp_out   = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
    end

    // Reset with random traffic
    for (int k = 0; k < 2; k++)
      step(COLS'($urandom), 1'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    check("rst_out", bus.out, '0);
    check("rst_valid", W'(bus.o_valid), '0);
    check("rst_full", W'(bus.o_full), '0);
    check("rst_ready", W'(bus.o_ready), W'(1));
`ifdef OFIFO_ERR_EN
    check("rst_err", W'(bus.o_err), '0);
`endif

    for (int k = 0; k < 15; k++) begin
      step(tbl[k].wr, tbl[k].rd, tbl[k].din, 1'b0);
      check("skew_valid", W'(bus.o_valid), W'(tbl[k].exp_valid));
      if (tbl[k].chk_out) check("skew_out", bus.out, tbl[k].exp_out);
    end

    // Full boundary on column 3
    step('0, 1'b0, '0, 1'b1);
    for (int j = 0; j < DEPTH; j++) begin
      d = '0;
      d[3*BW +: BW] = BW'(j);
      step(8'h08, 1'b0, d, 1'b0);
    end
    check("full_set", W'(bus.o_full), W'(1));
    check("full_ready", W'(bus.o_ready), '0);
    d = '0;
    d[3*BW +: BW] = 16'hDEAD;
    step(8'h08, 1'b0, d, 1'b0);
    check("full_hold", W'(bus.o_full), W'(1));
`ifdef OFIFO_ERR_EN
    check("drop_err", W'(bus.o_err), W'(1));
`endif
    step(8'hF7, 1'b0, mkrow(16'h5000), 1'b0);
    check("full_valid", W'(bus.o_valid), W'(1));
    step('0, 1'b1, '0, 1'b0);
    check("full_clear", W'(bus.o_full), '0);
    check("full_ready2", W'(bus.o_ready), W'(1));
    check("full_out", bus.out, 128'h5007_5006_5005_5004_0000_5002_5001_5000);

    // Wrap-around: 200 rows with skewed writes and interleaved reads
    step('0, 1'b0, '0, 1'b1);
    drops = 0;
    rows_read = 0;
    for (int i = 0; i < COLS; i++) wcnt[i] = 0;
    guard = 0;
    while (rows_read < 200 && guard < 3000) begin
      w = '0;
      d = '0;
      for (int i = 0; i < COLS; i++) begin
        if (wcnt[i] < 200 && $urandom_range(0, 1) == 1) begin
          w[i] = 1'b1;
          d[i*BW +: BW] = {4'(i), 12'(wcnt[i])};
          wcnt[i]++;
        end
      end
      step(w, 1'($urandom_range(0, 3) != 0), d, 1'b0);
      guard++;
    end
    check("wrap_rows", W'(rows_read), W'(200));
    check("wrap_drops", W'(drops), '0);
    check("wrap_empty", W'(bus.o_valid), '0);
`ifdef OFIFO_ERR_EN
    check("wrap_err", W'(bus.o_err), '0);
`endif

    // Simultaneous read and write on column 0 at count 1
    step('0, 1'b0, '0, 1'b1);
    step(8'hFF, 1'b0, mkrow(16'hA000), 1'b0);
    step(8'h01, 1'b1, mkrow(16'hB000), 1'b0);
    check("rw_out", bus.out, 128'hA007_A006_A005_A004_A003_A002_A001_A000);
    check("rw_valid", W'(bus.o_valid), '0);
    step(8'hFE, 1'b0, mkrow(16'hC000), 1'b0);
    check("rw_valid2", W'(bus.o_valid), W'(1));
    step('0, 1'b1, '0, 1'b0);
    check("rw_out2", bus.out, 128'hC007_C006_C005_C004_C003_C002_C001_B000);

    // Mid-operation reset
    step('0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 10; k++) step(8'hFF, 1'b0, mkrow(16'hD000 + 16'(k << 4)), 1'b0);
    step(8'hFF, 1'b1, mkrow(16'h7700), 1'b1);
    check("mrst_valid", W'(bus.o_valid), '0);
    check("mrst_out", bus.out, '0);
    step(8'hFF, 1'b0, mkrow(16'hE000), 1'b0);
    step('0, 1'b1, '0, 1'b0);
    check("mrst_row", bus.out, 128'hE007_E006_E005_E004_E003_E002_E001_E000);
    check("mrst_valid2", W'(bus.o_valid), '0);
    step('0, 1'b1, '0, 1'b0);
    check("idle_rd_out", bus.out, 128'hE007_E006_E005_E004_E003_E002_E001_E000);
`ifdef OFIFO_ERR_EN
    check("idle_rd_err", W'(bus.o_err), W'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ofifo_align.md
# ofifo_align

Output-side column aligner for the systolic MAC array: it collects partial sums that leave the array's columns on independent, skewed cycles and presents them as whole, aligned rows to the downstream reader (SFU / PSUM memory writer). Each column has its own circular buffer with its own write strobe. The reader pops one entry from every column at once, and only when all columns hold data. This block is the drain-side counterpart of the row-wise input buffer that feeds the array.

## Interface
- `col`, 8, number of array columns (independent lanes)
- `bw`, 16, bits per partial-sum entry
- `depth`, 64, entries per column; power of two, ≥ 2
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high
- `in`  in  col*bw  write data; column i uses `in[i*bw +: bw]`
- `wr`  in  col  per-column write strobe; bit i writes column i
- `rd`  in  1  aligned-row read request
- `out`  out  col*bw  registered read data; column i on `out[i*bw +: bw]`
- `o_valid`  out  1  every column holds ≥ 1 entry
- `o_full`  out  1  at least one column holds `depth` entries
- `o_ready`  out  1  equals `~o_full`
- `o_err`  out  1  sticky error flag; present only with `OFIFO_ERR_EN`

## Operation
- Per-column state: write pointer, read pointer, and occupancy count (log2(depth)+1 bits). Pointers wrap modulo `depth`.
- Per-column flags: `empty[i]` = (count==0); `full[i]` = (count==depth).
- Outputs: `o_valid = &~empty`; `o_full = |full`. Both are combinational from registered counts.
- Write accept: `wr[i] & ~full[i]`. The entry is stored at the write pointer, and the pointer and count advance. A write to a full column is dropped, with no state change.
- Read accept: `rd & o_valid`. On acceptance, every column's head entry is loaded into `out`, all read pointers advance, and all counts decrement. A read with `o_valid`=0 is ignored.
- `out` holds its value when no read is accepted.
- Same-cycle read and write on a column: both are evaluated against start-of-cycle flags. The count changes by +1 only, −1 only, or stays the same.
  - A full column with both `wr` and an accepted `rd` still drops the write.
  - An empty column cannot be read: `o_valid` is 0, so a same-cycle write lands.
- Columns are otherwise fully independent. Skewed, bursty or idle writes per column are all legal.

## Timing
- Reset (synchronous): all pointers and counts go to 0 and `out` goes to 0. Consequently `o_valid`=0, `o_full`=0, `o_ready`=1, and `o_err`=0.
- Reset mid-operation discards all stored data. It takes precedence over same-cycle `wr`/`rd`.
- Write at edge t: `empty[i]`/`full[i]` reflect it from cycle t+1.
- Read accepted in cycle t: `out` shows the aligned row from cycle t+1, which is 1-cycle latency. `o_valid` updates in t+1.
- Back-to-back reads are legal at full rate while `o_valid` stays 1.
- Throughput: 1 write per column per cycle and 1 aligned read per cycle.

## Configuration
- `OFIFO_ERR_EN` defined:
  - Port `o_err` exists.
  - It is set to 1 on any dropped write (`wr[i] & full[i]`) or ignored read (`rd & ~o_valid`).
  - It stays set until reset.
- `OFIFO_ERR_EN` undefined:
  - Port `o_err` and its logic are absent.
  - Dropped writes and ignored reads are silent.
  - All other behaviour is identical.

## Test plan
- Reset check:
  - Assert `reset` 2 cycles with random `wr`/`rd`.
  - Required: `out`=0, `o_valid`=0, `o_full`=0, `o_ready`=1, `o_err`=0.
- Skewed fill (col=8):
  - Column i writes value 16'h0100+i starting at cycle i, one per cycle, for 4 cycles.
  - Required: `o_valid` stays 0 until the cycle after column 7's first write, then goes to 1.
  - Then `rd` for 4 cycles. Required: `out` column i = 16'h0100+i on each read, in write order, and `o_valid`=0 after the 4th read.
- Full boundary (depth=64):
  - Write 64 entries to column 3 only. Required: `o_full`=1 and `o_ready`=0 from the next cycle.
  - A 65th write is dropped. Required: `o_err`=1 (with the macro).
  - Fill the other columns and read once. Required: `o_full` clears.
- Wrap-around:
  - Stream 200 rows through all columns with interleaved `rd`.
  - Required: the `out` sequence matches a reference model exactly, and no drops occur.
- Simultaneous read/write:
  - Column 0 count=1, all other columns at count=1, `wr[0]`=1 and `rd`=1 in the same cycle.
  - Required: column 0 count stays 1, `out` = old head, and the new data appears on the next read.
- Mid-operation reset:
  - Reset with 10 rows stored, then write 1 row and read.
  - Required: `out` = the new row only, and `o_valid`=0 afterwards.
  - Also drive `rd` with `o_valid`=0. Required: `out` unchanged and `o_err`=1 (with the macro).
